fp_cmp_pipe: RTL and testbench

- Parametrised, pipelined floating-point compare / min-max unit for the RISCV32F datapath.
- Executes FEQ, FLT, FLE, FMIN and FMAX on IEEE-754 operands of configurable format.
- Raises the invalid (NV) flag per the RISC-V F rules.
- Sits between the FP register-file read stage and writeback; valid/ready handshakes on both sides.

---
 rtl/fp_cmp_pipe.sv | 78 +++++++
 tb/tb_fp_cmp_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: pipelined IEEE-754 compare / min-max unit (FEQ, FLT, FLE, FMIN, FMAX) with NV flag.
module fp_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LAT = 2,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         invalid
);
  localparam logic [W-1:0] CNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic sa, sb, na, nb, sna, snb, za, zb, mlt, mgt, ltt, lt, eq, cmp, is_mm, inv;
  logic [W-1:0] mn, mx, res;
  logic [W-1:0] r [LAT];
  logic [W-1:0] rx [LAT+1];
  logic [LAT-1:0] v, n, ld;
  logic [LAT:0] vx, nx;
  assign sa = a[W-1];
  assign sb = b[W-1];
  assign na = &a[W-2:MAN_W] & |a[MAN_W-1:0];
  assign nb = &b[W-2:MAN_W] & |b[MAN_W-1:0];
  assign sna = na & !a[MAN_W-1];
  assign snb = nb & !b[MAN_W-1];
  assign za = ~|a[W-2:0];
  assign zb = ~|b[W-2:0];
  assign mlt = a[W-2:0] < b[W-2:0];
  assign mgt = a[W-2:0] > b[W-2:0];
  // ltt orders -0 below +0 (min/max); lt treats the zeros as equal (FLT/FLE)
  assign ltt = (sa != sb) ? sa : (sa ? mgt : mlt);
  assign lt = ltt & !(za & zb);
  assign eq = (a == b) | (za & zb);
  assign cmp = !na & !nb & (op[1] ? eq : (op[0] ? lt : (lt | eq)));
  assign is_mm = (op == 3'b100) | (op == 3'b101);
  assign mn = (na & nb) ? CNAN : na ? b : nb ? a : (ltt ? a : b);
  assign mx = (na & nb) ? CNAN : na ? b : nb ? a : (ltt ? b : a);
  always_comb begin
    res = (op == 3'b000 || op == 3'b001 || op == 3'b010) ? {{(W-1){1'b0}}, cmp} :
          is_mm ? (op[0] ? mx : mn) : '0;
    inv = (op == 3'b000 || op == 3'b001) ? (na | nb) :
          ((op == 3'b010) | is_mm) & (sna | snb);
  end
  // a stage may load when it or any later stage is empty, or the output drains
  for (genvar g = 0; g < LAT; g++) begin : g_ld
    assign ld[g] = out_ready | ~&v[LAT-1:g];
  end
  assign vx = {v, in_valid};
  assign nx = {n, in_valid & inv};
  always_comb begin
    rx[0] = in_valid ? res : '0;
    for (int k = 0; k < LAT; k++) rx[k+1] = r[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      n <= '0;
      for (int k = 0; k < LAT; k++) r[k] <= '0;
    end else begin
      for (int k = 0; k < LAT; k++)
        if (ld[k]) begin
          v[k] <= vx[k];
          n[k] <= nx[k];
          r[k] <= rx[k];
        end
    end
  assign in_ready = rst_n & ld[0];
  assign out_valid = v[LAT-1];
  assign result = r[LAT-1];
  assign invalid = n[LAT-1];
endmodule

// File: tb/tb_fp_cmp_pipe.sv
// tb_fp_cmp_pipe: directed self-checking bench for fp_cmp_pipe (single LAT=2 and double LAT=4).
module tb_fp_cmp_pipe;
  localparam int LAT = 2;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 1, in_ready, out_valid, invalid;
  logic [31:0] a = 0, b = 0, result;
  logic [2:0] op = 0;
  logic iv_d = 0, ir_d, ov_d, inv_d;
  logic [63:0] a_d = 0, b_d = 0, res_d;
  logic [2:0] op_d = 0;
  int n_chk = 0, n_fail = 0, nin = 0, nout = 0, cnt;
  logic stall = 0, saw_full = 0;
  logic [31:0] held;
  logic [5:0] pat = 6'b101001;
  logic [31:0] qa [4] = '{32'h3FC00000, 32'h40200000, 32'h3FC00000, 32'h40200000};
  logic [31:0] qb [4] = '{32'h40200000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000};
  logic [2:0]  qo [4] = '{3'b001, 3'b001, 3'b000, 3'b000};
  logic [31:0] qe [4] = '{32'd1, 32'd0, 32'd1, 32'd0};

  fp_cmp_pipe #(.EXP_W(8), .MAN_W(23), .LAT(LAT)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .invalid(invalid));
  fp_cmp_pipe #(.EXP_W(11), .MAN_W(52), .LAT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_d), .in_ready(ir_d), .a(a_d), .b(b_d), .op(op_d),
    .out_valid(ov_d), .out_ready(1'b1), .result(res_d), .invalid(inv_d));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [2:0] xo, input logic [31:0] er, input logic ei);
    a = xa; b = xb; op = xo; in_valid = 1;
    step;
    in_valid = 0;
    chk({tag, " early"}, 64'(out_valid), 64'd0);
    step;
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " invalid"}, 64'(invalid), 64'(ei));
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst invalid", 64'(invalid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    step; step;
    rst_n = 1;
    #1;
    chk("idle in_ready", 64'(in_ready), 64'd1);
    single("feq 2.5 2.5", 32'h40200000, 32'h40200000, 3'b010, 32'd1, 1'b0);
    single("feq 1.5 2.5", 32'h3FC00000, 32'h40200000, 3'b010, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin a = qa[i]; b = qb[i]; op = qo[i]; in_valid = 1; end
      else in_valid = 0;
      step;
      if (i > 0) begin
        chk("b2b valid", 64'(out_valid), 64'd1);
        chk("b2b result", 64'(result), 64'(qe[i-1]));
      end
    end
    single("feq +0 -0", 32'h00000000, 32'h80000000, 3'b010, 32'd1, 1'b0);
    single("fmin +0 -0", 32'h00000000, 32'h80000000, 3'b100, 32'h80000000, 1'b0);
    single("fmin -0 +0", 32'h80000000, 32'h00000000, 3'b100, 32'h80000000, 1'b0);
    single("fmax +0 -0", 32'h00000000, 32'h80000000, 3'b101, 32'h00000000, 1'b0);
    single("flt -0 +0", 32'h80000000, 32'h00000000, 3'b001, 32'd0, 1'b0);
    single("feq snan", 32'h7FA00000, 32'h3F800000, 3'b010, 32'd0, 1'b1);
    single("flt qnan", 32'h7FC00000, 32'h3F800000, 3'b001, 32'd0, 1'b1);
    single("feq qnan", 32'h7FC00000, 32'h3F800000, 3'b010, 32'd0, 1'b0);
    single("fmin qnan x", 32'h7FC00000, 32'h3F800000, 3'b100, 32'h3F800000, 1'b0);
    single("fmin qnan snan", 32'h7FC00000, 32'h7FA00000, 3'b100, 32'h7FC00000, 1'b1);
    single("fmax x snan", 32'h3F800000, 32'h7FA00000, 3'b101, 32'h3F800000, 1'b1);
    single("reserved op", 32'h3F800000, 32'h40000000, 3'b011, 32'd0, 1'b0);
    single("flt neg", 32'hBFC00000, 32'hC0200000, 3'b001, 32'd0, 1'b0);
    single("flt neg2", 32'hC0200000, 32'hBFC00000, 3'b001, 32'd1, 1'b0);
    single("fle denorm", 32'h00000002, 32'h00000001, 3'b000, 32'd0, 1'b0);
    single("flt denorm", 32'h00000001, 32'h00000002, 3'b001, 32'd1, 1'b0);
    single("fmax sign", 32'hBF800000, 32'h3F800000, 3'b101, 32'h3F800000, 1'b0);
    step;
    for (int c = 0; c < 40 && nout < 6; c++) begin
      out_ready = pat[c%6];
      in_valid = nin < 6;
      a = 32'h3F800000 + nin; b = 32'h0; op = 3'b101;
      #1;
      cnt = nin - nout;
      if (stall) begin
        chk("bp hold valid", 64'(out_valid), 64'd1);
        chk("bp hold result", 64'(result), 64'(held));
      end
      chk("bp in_ready", 64'(in_ready), 64'(!(cnt == LAT && !out_ready)));
      if (cnt == LAT && !out_ready) saw_full = 1;
      stall = out_valid & !out_ready;
      held = result;
      if (in_valid & in_ready) nin++;
      if (out_valid & out_ready) begin
        chk("bp order", 64'(result), 64'(32'h3F800000 + nout));
        nout++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    chk("bp count", 64'(nout), 64'd6);
    chk("bp saw full", 64'(saw_full), 64'd1);
    step; step;
    out_ready = 0;
    a = 32'h7FA00000; b = 32'h3F800000; op = 3'b100; in_valid = 1;
    step;
    a = 32'h40200000; b = 32'h40200000; op = 3'b010;
    step;
    in_valid = 0;
    chk("pre-rst valid", 64'(out_valid), 64'd1);
    chk("pre-rst result", 64'(result), 64'h3F800000);
    chk("pre-rst invalid", 64'(invalid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("async rst valid", 64'(out_valid), 64'd0);
    chk("async rst result", 64'(result), 64'd0);
    chk("async rst invalid", 64'(invalid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("post-rst stale", 64'(out_valid), 64'd0);
    end
    a_d = 64'h4004000000000000; b_d = 64'h4004000000000000; op_d = 3'b010; iv_d = 1;
    step;
    iv_d = 0;
    step; step;
    chk("dbl early", 64'(ov_d), 64'd0);
    step;
    chk("dbl valid", 64'(ov_d), 64'd1);
    chk("dbl result", res_d, 64'd1);
    chk("dbl invalid", 64'(inv_d), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
